// File: rtl/input_column_fifo.sv
// input_column_fifo
//   Circular column buffer with a ready/valid interface on both sides.
//   Each column holds LANES pixels of PIX_W bits.  They are presented on the
//   read side widened to LANE_W bits per lane, either zero- or sign-extended
//   as selected by sext.
//
// Ports
//   clk       : sole clock; all state updates on its rising edge
//   rst_n     : asynchronous active-low reset (pointers, level, overflow)
//   flush     : synchronous clear of pointers, level and overflow
//   sext      : 0 = zero-extend, 1 = sign-extend pixels to LANE_W
//   wr_valid  : a column is offered on wr_data
//   wr_ready  : the buffer can accept a column (level != DEPTH)
//   wr_data   : input column, lane i at [i*PIX_W +: PIX_W]
//   rd_valid  : rd_data holds the oldest stored column (level != 0)
//   rd_ready  : the consumer takes rd_data
//   rd_data   : extended column, lane i at [i*LANE_W +: LANE_W]
//   level     : number of stored columns
//   overflow  : sticky flag, set when a write is attempted while full
module input_column_fifo #(
    parameter int LANES  = 10,
    parameter int PIX_W  = 9,
    parameter int LANE_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      sext,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LANES*PIX_W-1:0]    wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [LANES*LANE_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [LANES*PIX_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic wr_fire;
    logic rd_fire;

    // Handshake flags come only from the registered level, so there is no
    // combinational path from rd_ready to wr_ready.
    assign wr_ready = (level_q != LW'(DEPTH));
    assign rd_valid = (level_q != '0);
    assign level    = level_q;
    assign overflow = ovf_q;

    assign wr_fire = wr_valid && wr_ready && !flush;
    assign rd_fire = rd_valid && rd_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            // A write while full is dropped and flagged, even if a read is
            // accepted on the same edge.
            if (wr_valid && !wr_ready) begin
                ovf_d = 1'b1;
            end
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                level_d = level_q + LW'(1);
            end else if (rd_fire && !wr_fire) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never cleared.  A write during reset can only land in a slot
    // that is empty once reset ends, and it is overwritten before anything
    // reads it, so the write enable does not need to include rst_n.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    logic [LANES*PIX_W-1:0] head;
    assign head = mem_q[rd_ptr_q];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PIX_W-1:0] pix;
        assign pix = head[i*PIX_W +: PIX_W];
        if (LANE_W == PIX_W) begin : g_same
            assign rd_data[i*LANE_W +: LANE_W] = pix;
        end else begin : g_ext
            assign rd_data[i*LANE_W +: LANE_W] =
                {{(LANE_W-PIX_W){sext & pix[PIX_W-1]}}, pix};
        end
    end

endmodule

// File: tb/tb_input_column_fifo.sv
module tb_input_column_fifo;

    localparam int LANES  = 10;
    localparam int PIX_W  = 9;
    localparam int LANE_W = 16;
    localparam int DEPTH  = 4;
    localparam int IW     = LANES * PIX_W;
    localparam int OW     = LANES * LANE_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          sext;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [OW-1:0] rd_data;
    logic [2:0]    level;
    logic          overflow;

    input_column_fifo #(
        .LANES (LANES),
        .PIX_W (PIX_W),
        .LANE_W(LANE_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .sext    (sext),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data (rd_data),
        .level   (level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of stored columns (oldest first) and sticky flag model.
    logic [IW-1:0] sb[$];
    logic          movf;

    logic [IW-1:0] bank [8];

    typedef struct {
        logic        wv;
        logic        rr;
        logic        fl;
        logic        sx;
        int unsigned col;
        int unsigned exp_level;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] ext(input logic [IW-1:0] c, input logic sx);
        logic [OW-1:0] r;
        logic [PIX_W-1:0] p;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            p = c[i*PIX_W +: PIX_W];
            r[i*LANE_W +: LANE_W] = sx ? {{(LANE_W-PIX_W){p[PIX_W-1]}}, p}
                                       : {{(LANE_W-PIX_W){1'b0}}, p};
        end
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, compare against the model
    // just after, then advance the model on the rising edge.
    task automatic step(input logic wv, input logic [IW-1:0] wd, input logic rr,
                        input logic fl, input logic sx);
        int ml;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        sext     = sx;
        #1;
        ml = sb.size();
        chk("level",    OW'(level),    OW'(ml));
        chk("rd_valid", OW'(rd_valid), OW'(ml != 0));
        chk("wr_ready", OW'(wr_ready), OW'(ml != DEPTH));
        chk("overflow", OW'(overflow), OW'(movf));
        if (ml != 0) chk("rd_data", rd_data, ext(sb[0], sx));
        @(posedge clk);
        if (!rst_n || fl) begin
            sb.delete();
            movf = 1'b0;
        end else begin
            if (wv && ml == DEPTH) movf = 1'b1;
            if (rr && ml != 0) void'(sb.pop_front());
            if (wv && ml != DEPTH) sb.push_back(wd);
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [IW-1:0] spec_col;

        for (int i = 0; i < 8; i++) bank[i] = {$urandom, $urandom, $urandom};

        //            wv    rr    fl    sx  col lvl ovf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 4, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 4, 1'b1};   // write while full
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5, 3, 1'b1};   // full write + read
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 2, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};   // read while empty
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};   // flush clears flag

        rst_n = 1'b0; flush = 1'b0; sext = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        sb.delete(); movf = 1'b0;
        #23 rst_n = 1'b1;
        idle();

        // Table-driven fill, overflow, drain, empty read, flush.
        foreach (tbl[i]) begin
            step(tbl[i].wv, bank[tbl[i].col], tbl[i].rr, tbl[i].fl, tbl[i].sx);
            #1;
            chk($sformatf("tbl%0d_level", i), OW'(level), OW'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_ovf", i), OW'(overflow), OW'(tbl[i].exp_ovf));
        end

        // Known column: lanes 0..2 = 1FF, 000, 101; the rest arbitrary.
        spec_col = '0;
        spec_col[0*PIX_W +: PIX_W] = 9'h1FF;
        spec_col[1*PIX_W +: PIX_W] = 9'h000;
        spec_col[2*PIX_W +: PIX_W] = 9'h101;
        for (int i = 3; i < LANES; i++) spec_col[i*PIX_W +: PIX_W] = PIX_W'(i * 37);
        step(1'b1, spec_col, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0; sext = 1'b0;
        #1;
        chk("zx_valid", OW'(rd_valid), OW'(1));
        chk("zx_level", OW'(level), OW'(1));
        chk("zx_lane0", OW'(rd_data[15:0]),  OW'(16'h01FF));
        chk("zx_lane2", OW'(rd_data[47:32]), OW'(16'h0101));
        sext = 1'b1;
        #1;
        chk("sx_lane0", OW'(rd_data[15:0]),  OW'(16'hFFFF));
        chk("sx_lane1", OW'(rd_data[31:16]), OW'(16'h0000));
        chk("sx_lane2", OW'(rd_data[47:32]), OW'(16'hFF01));
        idle();   // stability while not read

        // Streaming at level 2 across pointer wrap.
        step(1'b1, bank[6], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, {$urandom, $urandom, $urandom}, 1'b1, 1'b0, i[0]);
        #1;
        chk("stream_level", OW'(level), OW'(2));

        // Level 3 with overflow set, then flush with a coincident write.
        step(1'b1, bank[7], 1'b0, 1'b0, 1'b0);
        step(1'b1, bank[0], 1'b0, 1'b0, 1'b0);
        step(1'b1, bank[1], 1'b0, 1'b0, 1'b0);   // full: sets overflow
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);        // level 3
        step(1'b1, bank[2], 1'b0, 1'b1, 1'b0);   // flush + write
        #1;
        chk("flush_level", OW'(level), OW'(0));
        chk("flush_ovf",   OW'(overflow), OW'(0));
        chk("flush_valid", OW'(rd_valid), OW'(0));
        idle();

        // Asynchronous reset between edges at level 2.
        step(1'b1, bank[3], 1'b0, 1'b0, 1'b0);
        step(1'b1, bank[4], 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", OW'(rd_valid), OW'(0));
        chk("arst_level", OW'(level), OW'(0));
        chk("arst_ready", OW'(wr_ready), OW'(1));
        sb.delete(); movf = 1'b0;
        step(1'b1, bank[5], 1'b0, 1'b0, 1'b0);   // write during reset is ignored
        #2 rst_n = 1'b1;
        idle();
        step(1'b1, bank[6], 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_level", OW'(level), OW'(1));
        chk("post_rst_data",  rd_data, ext(bank[6], 1'b0));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/input_column_fifo.md
INPUT_COLUMN_FIFO -- requirements
Module: input_column_fifo

Interface
REQ-001 Parameter LANES, default 10: pixels per input column.
REQ-002 Parameter PIX_W, default 9: bits per input pixel.
REQ-003 Parameter LANE_W, default 16: bits per output lane; SHALL be >= PIX_W.
REQ-004 Parameter DEPTH, default 4: column entries stored; SHALL be a power of two, >= 2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of contents and error flag.
REQ-008 sext  input  1  extension mode: 0 = zero-extend, 1 = sign-extend pixels to LANE_W.
REQ-009 wr_valid  input  1  column offered on wr_data.
REQ-010 wr_ready  output  1  buffer can accept a column.
REQ-011 wr_data  input  LANES*PIX_W  column; lane i at bits [i*PIX_W +: PIX_W].
REQ-012 rd_valid  output  1  rd_data holds the oldest stored column.
REQ-013 rd_ready  input  1  consumer takes rd_data.
REQ-014 rd_data  output  LANES*LANE_W  extended column; lane i at bits [i*LANE_W +: LANE_W].
REQ-015 level  output  $clog2(DEPTH)+1  number of stored columns.
REQ-016 overflow  output  1  sticky: write attempted while full.

Function
REQ-017 Storage SHALL be a DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter, pointers wrapping from DEPTH-1 to 0.
REQ-018 wr_ready SHALL equal (level != DEPTH), decoded from registered state only; no combinational path from rd_ready.
REQ-019 rd_valid SHALL equal (level != 0), decoded from registered state only.
REQ-020 Write accepted on an edge where wr_valid && wr_ready && !flush: column stored at write pointer, pointer advances.
REQ-021 Read accepted on an edge where rd_valid && rd_ready && !flush: read pointer advances.
REQ-022 level SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-023 Write-to-read latency: a column accepted into an empty buffer at edge k SHALL be on rd_data with rd_valid=1 in the cycle after edge k; no same-cycle bypass.
REQ-024 rd_data SHALL be combinational from the entry at the read pointer and current sext; per lane, upper LANE_W-PIX_W bits = 0 when sext=0, = pixel MSB when sext=1.
REQ-025 When LANE_W == PIX_W, rd_data lanes SHALL equal stored pixels unmodified regardless of sext.
REQ-026 rd_data SHALL be stable while rd_valid=1 and rd_ready=0, given stable sext.
REQ-027 When full, wr_valid=1 SHALL not alter storage and SHALL set overflow on that edge, even if a read is accepted on the same edge.
REQ-028 rd_ready=1 while empty SHALL be ignored; pointers and level unchanged; no error flag.
REQ-029 flush=1 at an edge SHALL zero both pointers, level and overflow, overriding any coincident write or read.
REQ-030 overflow SHALL remain 1 until flush or reset.
REQ-031 Stored entry contents are not cleared by flush or reset; rd_data is don't-care while rd_valid=0.

Reset
REQ-032 rst_n=0 SHALL immediately, without clk, force pointers=0, level=0, overflow=0, hence wr_ready=1, rd_valid=0.
REQ-033 Deassertion of rst_n mid-stream SHALL leave the buffer empty; columns held before reset SHALL never be presented.
REQ-034 No write or read SHALL be accepted on an edge where rst_n=0.

Verification
REQ-035 Default params, sext=0: write lanes 0..9 = 9'h1FF,9'h000,9'h101,... ; next cycle rd_valid=1, lane0=16'h01FF, lane2=16'h0101; level=1.
REQ-036 Same column with sext=1 -> lane0=16'hFFFF, lane1=16'h0000, lane2=16'hFF01.
REQ-037 Write 4 distinct columns, rd_ready=0 -> level=4, wr_ready=0; fifth wr_valid -> overflow=1, contents unchanged; drain -> columns 1..4 in order, then rd_valid=0.
REQ-038 Hold level=2, assert wr_valid and rd_ready together for 10 cycles -> level stays 2, output order matches input order across pointer wrap.
REQ-039 Level=3, overflow=1, pulse flush with coincident write -> level=0, overflow=0, rd_valid=0, write discarded.
REQ-040 Level=2, assert rst_n=0 between clock edges -> rd_valid=0, level=0 before next edge; after release, next write visible one cycle later with level=1.
